// File: rtl/seq_divider_4bit_pkg.sv
// rtl/seq_divider_4bit_pkg.sv - shared state encoding and widths for the restoring divider
package seq_divider_4bit_pkg;

   localparam int DIV_WIDTH = 4;
   localparam int CNT_W     = $clog2(DIV_WIDTH);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_CALC = 2'd1,
      S_DONE = 2'd2
   } state_t;

endpackage

// File: rtl/seq_divider_4bit_if.sv
// rtl/seq_divider_4bit_if.sv - start/done request and result bundle of the divider
interface seq_divider_4bit_if
   import seq_divider_4bit_pkg::*;
#(
   parameter int WIDTH = DIV_WIDTH
);

   logic             start;
   logic [WIDTH-1:0] dividend;
   logic [WIDTH-1:0] divisor;
   logic             busy;
   logic             done;
   logic [WIDTH-1:0] quotient;
   logic [WIDTH-1:0] remainder;
   logic             div_by_zero;

   modport master (
      output start, dividend, divisor,
      input  busy, done, quotient, remainder, div_by_zero
   );

   modport slave (
      input  start, dividend, divisor,
      output busy, done, quotient, remainder, div_by_zero
   );

endinterface

// File: rtl/seq_divider_4bit_div_step.sv
// rtl/seq_divider_4bit_div_step.sv - one restoring-division step built from nand full adders
module seq_divider_4bit_nand_fa (
   input  logic a,
   input  logic b,
   input  logic cin,
   output logic sum,
   output logic cout
);

   logic n1, n2, n3, x1, n4, n5, n6;

   // Classic nine-nand full adder: first half-adder forms a^b, second folds in cin.
   assign n1   = ~(a & b);
   assign n2   = ~(a & n1);
   assign n3   = ~(b & n1);
   assign x1   = ~(n2 & n3);
   assign n4   = ~(x1 & cin);
   assign n5   = ~(x1 & n4);
   assign n6   = ~(cin & n4);
   assign sum  = ~(n5 & n6);
   assign cout = ~(n1 & n4);

endmodule

module seq_divider_4bit_div_step #(
   parameter int WIDTH = 4
) (
   input  logic [WIDTH-1:0] rem_in,
   input  logic             bit_in,
   input  logic [WIDTH-1:0] divisor,
   output logic [WIDTH-1:0] rem_out,
   output logic             q_bit
);

   logic [WIDTH:0]   shifted;
   logic [WIDTH:0]   dext;
   logic [WIDTH:0]   dinv;
   logic [WIDTH:0]   diff;
   logic [WIDTH+1:0] carry;

   // Partial remainder shifted left with the next dividend bit; needs WIDTH+1 bits.
   assign shifted  = {rem_in, bit_in};
   assign dext     = {1'b0, divisor};
   assign carry[0] = 1'b1;

   // Ripple subtract shifted - divisor as shifted + ~divisor + 1; carry out high means no borrow.
   for (genvar i = 0; i <= WIDTH; i++) begin : g_bit
      assign dinv[i] = ~(dext[i] & dext[i]);
      seq_divider_4bit_nand_fa u_fa (
         .a    (shifted[i]),
         .b    (dinv[i]),
         .cin  (carry[i]),
         .sum  (diff[i]),
         .cout (carry[i+1])
      );
   end

   // Without a borrow the difference is below the divisor, so its top bit is always clear.
   assign q_bit   = carry[WIDTH+1] & ~diff[WIDTH];
   assign rem_out = q_bit ? diff[WIDTH-1:0] : shifted[WIDTH-1:0];

endmodule

// File: rtl/seq_divider_4bit.sv
// rtl/seq_divider_4bit.sv - sequential restoring divider, one quotient bit per clock
module seq_divider_4bit
   import seq_divider_4bit_pkg::*;
#(
   parameter int WIDTH = DIV_WIDTH
) (
   input  logic              clk,
   input  logic              rst,
   seq_divider_4bit_if.slave bus
);

   state_t           state_q, state_d;
   logic [CNT_W-1:0] cnt_q;
   logic [WIDTH-1:0] r_q;
   logic [WIDTH-1:0] q_q;
   logic [WIDTH-1:0] d_q;
   logic             dz_q;
   logic [WIDTH-1:0] quotient_q;
   logic [WIDTH-1:0] remainder_q;
   logic             div_by_zero_q;
   logic             done_q;
   logic [WIDTH-1:0] step_rem;
   logic             step_q;

   seq_divider_4bit_div_step #(.WIDTH(WIDTH)) u_step (
      .rem_in  (r_q),
      .bit_in  (q_q[WIDTH-1]),
      .divisor (d_q),
      .rem_out (step_rem),
      .q_bit   (step_q)
   );

   // State register.
   always_ff @(posedge clk) begin
      if (rst) state_q <= S_IDLE;
      else     state_q <= state_d;
   end

   // Next state: a zero divisor skips the iteration entirely.
   always_comb begin
      state_d = state_q;
      case (state_q)
         S_IDLE: if (bus.start) state_d = (bus.divisor != '0) ? S_CALC : S_DONE;
         S_CALC: if (cnt_q == '0) state_d = S_DONE;
         S_DONE: state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   // Datapath: capture operands on accept, iterate in CALC, publish results out of DONE.
   always_ff @(posedge clk) begin
      if (rst) begin
         cnt_q         <= '0;
         r_q           <= '0;
         q_q           <= '0;
         d_q           <= '0;
         dz_q          <= 1'b0;
         quotient_q    <= '0;
         remainder_q   <= '0;
         div_by_zero_q <= 1'b0;
         done_q        <= 1'b0;
      end else begin
         done_q <= 1'b0;
         case (state_q)
            S_IDLE: begin
               if (bus.start) begin
                  if (bus.divisor != '0) begin
                     r_q  <= '0;
                     q_q  <= bus.dividend;
                     d_q  <= bus.divisor;
                     cnt_q <= CNT_W'(WIDTH - 1);
                     dz_q <= 1'b0;
                  end else begin
                     r_q  <= bus.dividend;
                     q_q  <= '1;
                     d_q  <= '0;
                     dz_q <= 1'b1;
                  end
               end
            end
            S_CALC: begin
               r_q <= step_rem;
               q_q <= {q_q[WIDTH-2:0], step_q};
               if (cnt_q != '0) cnt_q <= cnt_q - 1'b1;
            end
            S_DONE: begin
               quotient_q    <= q_q;
               remainder_q   <= r_q;
               div_by_zero_q <= dz_q;
               done_q        <= 1'b1;
            end
            default: ;
         endcase
      end
   end

   assign bus.busy        = (state_q != S_IDLE);
   assign bus.done        = done_q;
   assign bus.quotient    = quotient_q;
   assign bus.remainder   = remainder_q;
   assign bus.div_by_zero = div_by_zero_q;

endmodule

// File: tb/tb_seq_divider_4bit.sv
// tb/tb_seq_divider_4bit.sv - directed and exhaustive self-checking bench for seq_divider_4bit
module tb_seq_divider_4bit;

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   checks   = 0;
   int   failures = 0;
   int   done_cnt = 0;

   seq_divider_4bit_if #(.WIDTH(4)) bus ();

   seq_divider_4bit dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   always #5 clk = ~clk;

   // Count every done pulse seen, sampled away from the active edge.
   always @(negedge clk) if (bus.done === 1'b1) done_cnt++;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         failures++;
         $display("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Issue one request from an idle DUT and wait (bounded) for its done pulse.
   task automatic run_op(input logic [3:0] a, input logic [3:0] b, output int lat, output int bcnt);
      bus.start    = 1'b1;
      bus.dividend = a;
      bus.divisor  = b;
      @(posedge clk); #1;
      bus.start    = 1'b0;
      bus.dividend = ~a;
      bus.divisor  = b + 4'd3;
      lat  = 0;
      bcnt = 0;
      while (bus.done !== 1'b1 && lat < 12) begin
         if (bus.busy === 1'b1) bcnt++;
         @(posedge clk); #1;
         lat++;
      end
   endtask

   task automatic idle_cycles(input int n);
      for (int k = 0; k < n; k++) begin
         @(posedge clk); #1;
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog observed=timeout expected=finish");
      $fatal(1);
   end

   initial begin
      int lat, bcnt, d0;
      logic [3:0] dvd, dvs;
      logic [8:0] exp_res;

      bus.start    = 1'b0;
      bus.dividend = 4'd0;
      bus.divisor  = 4'd0;
      rst = 1'b1;
      idle_cycles(3);
      rst = 1'b0;
      check("rst_busy", 32'(bus.busy), 32'd0);
      check("rst_done", 32'(bus.done), 32'd0);
      check("rst_q",    32'(bus.quotient), 32'd0);
      check("rst_r",    32'(bus.remainder), 32'd0);
      check("rst_dz",   32'(bus.div_by_zero), 32'd0);
      idle_cycles(1);

      // 13 / 3: five edges to done, busy through 4 CALC cycles plus DONE.
      d0 = done_cnt;
      run_op(4'd13, 4'd3, lat, bcnt);
      check("13_3_lat",  32'(lat), 32'd5);
      check("13_3_busy", 32'(bcnt), 32'd5);
      check("13_3_busy_at_done", 32'(bus.busy), 32'd0);
      check("13_3_q",  32'(bus.quotient), 32'd4);
      check("13_3_r",  32'(bus.remainder), 32'd1);
      check("13_3_dz", 32'(bus.div_by_zero), 32'd0);
      idle_cycles(1);
      check("13_3_pulse_len", 32'(bus.done), 32'd0);
      check("13_3_pulses", 32'(done_cnt - d0), 32'd1);

      run_op(4'd15, 4'd1, lat, bcnt);
      check("15_1_q", 32'(bus.quotient), 32'd15);
      check("15_1_r", 32'(bus.remainder), 32'd0);
      run_op(4'd2, 4'd9, lat, bcnt);
      check("2_9_q", 32'(bus.quotient), 32'd0);
      check("2_9_r", 32'(bus.remainder), 32'd2);
      run_op(4'd0, 4'd5, lat, bcnt);
      check("0_5_q", 32'(bus.quotient), 32'd0);
      check("0_5_r", 32'(bus.remainder), 32'd0);

      // Divide by zero, then a normal op must clear the flag.
      run_op(4'd7, 4'd0, lat, bcnt);
      check("7_0_lat", 32'(lat), 32'd1);
      check("7_0_q",   32'(bus.quotient), 32'd15);
      check("7_0_r",   32'(bus.remainder), 32'd7);
      check("7_0_dz",  32'(bus.div_by_zero), 32'd1);
      run_op(4'd6, 4'd2, lat, bcnt);
      check("6_2_q",  32'(bus.quotient), 32'd3);
      check("6_2_r",  32'(bus.remainder), 32'd0);
      check("6_2_dz", 32'(bus.div_by_zero), 32'd0);
      idle_cycles(2);

      // 12 / 5 with a second request 9 / 4 pulsed mid-CALC; it must be dropped.
      d0 = done_cnt;
      bus.start = 1'b1; bus.dividend = 4'd12; bus.divisor = 4'd5;
      @(posedge clk); #1;
      bus.start = 1'b0;
      @(posedge clk); #1;
      bus.start = 1'b1; bus.dividend = 4'd9; bus.divisor = 4'd4;
      @(posedge clk); #1;
      bus.start = 1'b0;
      lat = 0;
      while (bus.done !== 1'b1 && lat < 12) begin
         @(posedge clk); #1;
         lat++;
      end
      check("12_5_timeout", 32'(lat < 12), 32'd1);
      check("12_5_q", 32'(bus.quotient), 32'd2);
      check("12_5_r", 32'(bus.remainder), 32'd2);
      idle_cycles(10);
      check("12_5_pulses", 32'(done_cnt - d0), 32'd1);
      check("12_5_idle", 32'(bus.busy), 32'd0);

      // Reset in the second CALC cycle of 14 / 3.
      d0 = done_cnt;
      bus.start = 1'b1; bus.dividend = 4'd14; bus.divisor = 4'd3;
      @(posedge clk); #1;
      bus.start = 1'b0;
      @(posedge clk); #1;
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      check("rst_mid_busy", 32'(bus.busy), 32'd0);
      check("rst_mid_done", 32'(bus.done), 32'd0);
      check("rst_mid_q",    32'(bus.quotient), 32'd0);
      check("rst_mid_r",    32'(bus.remainder), 32'd0);
      check("rst_mid_dz",   32'(bus.div_by_zero), 32'd0);
      idle_cycles(8);
      check("rst_mid_pulses", 32'(done_cnt - d0), 32'd0);
      run_op(4'd14, 4'd3, lat, bcnt);
      check("14_3_q", 32'(bus.quotient), 32'd4);
      check("14_3_r", 32'(bus.remainder), 32'd2);
      idle_cycles(2);

      // Exhaustive sweep with start held high; the next pair is driven right after each accept.
      bus.start    = 1'b1;
      bus.dividend = 4'd0;
      bus.divisor  = 4'd0;
      for (int i = 0; i < 256; i++) begin
         dvd = 4'(i >> 4);
         dvs = 4'(i);
         @(posedge clk); #1;
         if (i == 255) begin
            bus.start = 1'b0;
         end else begin
            bus.dividend = 4'((i + 1) >> 4);
            bus.divisor  = 4'(i + 1);
         end
         lat = 0;
         while (bus.done !== 1'b1 && lat < 12) begin
            @(posedge clk); #1;
            lat++;
         end
         if (dvs == 4'd0) exp_res = {1'b1, 4'hF, dvd};
         else             exp_res = {1'b0, dvd / dvs, dvd % dvs};
         check($sformatf("sweep_lat_%0d_%0d", dvd, dvs), 32'(lat), (dvs == 4'd0) ? 32'd1 : 32'd5);
         check($sformatf("sweep_%0d_%0d", dvd, dvs),
               32'({bus.div_by_zero, bus.quotient, bus.remainder}), 32'(exp_res));
         if (dvs != 4'd0) begin
            for (int a = 0; a < 16; a++) begin
               if (a * int'(dvs) == int'(dvd)) begin
                  check($sformatf("mul_inv_%0d_%0d", a, dvs), 32'(bus.quotient), 32'(a));
                  check($sformatf("mul_inv_r_%0d_%0d", a, dvs), 32'(bus.remainder), 32'd0);
               end
            end
         end
      end
      idle_cycles(3);
      check("sweep_end_idle", 32'(bus.busy), 32'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
